aes_scan_sequencer: RTL and testbench

- Sequences one AES encryption on the external AES test ASIC over its scan interface: core reset, serial load of key and plaintext, Krdy/Drdy handshakes, BSY tracking, serial readback of ciphertext, compare against an expected value.
- Sits inside the FPGA top, between the start/reset buttons and the ASIC pins (RSTn, EN, SU, SE, SI, SCLK, Krdy, Drdy, SO, BSY).
- Drives the pass and fail LEDs.

---
 rtl/aes_scan_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_aes_scan_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_scan_sequencer.sv
// aes_scan_sequencer
// Runs one AES encryption on the external AES test ASIC through its scan
// interface: core reset, serial load of key and plaintext, Krdy/Drdy
// handshakes, BSY tracking, serial readback of the ciphertext and a compare
// against a reference value that drives the pass/fail LEDs.
//
// Ports
//   CLK, reset        system clock, synchronous active-high reset
//   start             level input, rising edge starts one run
//   key_in, pt_in     128-bit key / plaintext, latched at run start
//   expected          128-bit reference ciphertext, latched at run start
//   SO, BSY           scan-out and busy from the ASIC
//   RSTn, EN          ASIC reset (active-low) and enable
//   SU, SE, SI, SCLK  scan update, scan enable, scan-in, scan clock
//   Krdy, Drdy        key-ready / data-ready strobes
//   ct_out            captured ciphertext
//   done, pass, fail  run finished (sticky), compare result
//   timeout           a BSY wait ran out of SCLK periods
//
// Optional build macro AES_SEQ_CHAIN_EN: adds input expected_next[127:0].
// While start stays high after a passing run, a new run starts 16 CLK cycles
// into DONE with plaintext = previous ct_out and reference = expected_next.

module aes_scan_sequencer #(
  parameter int SCLK_DIV    = 4,
  parameter int RST_CYCLES  = 16,
  parameter int BSY_TIMEOUT = 4096
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [127:0] pt_in,
  input  logic [127:0] expected,
`ifdef AES_SEQ_CHAIN_EN
  input  logic [127:0] expected_next,
`endif
  input  logic         SO,
  input  logic         BSY,
  output logic         RSTn,
  output logic         EN,
  output logic         SU,
  output logic         SE,
  output logic         SI,
  output logic         SCLK,
  output logic         Krdy,
  output logic         Drdy,
  output logic [127:0] ct_out,
  output logic         done,
  output logic         pass,
  output logic         fail,
  output logic         timeout
);

  localparam logic [3:0] S_IDLE      = 4'd0,
                         S_CORE_RST  = 4'd1,
                         S_SHIFT_IN  = 4'd2,
                         S_UPDATE    = 4'd3,
                         S_KEY_RDY   = 4'd4,
                         S_WAIT_KEY  = 4'd5,
                         S_DATA_RDY  = 4'd6,
                         S_WAIT_HI   = 4'd7,
                         S_WAIT_LO   = 4'd8,
                         S_CAPTURE   = 4'd9,
                         S_SHIFT_OUT = 4'd10,
                         S_COMPARE   = 4'd11,
                         S_DONE      = 4'd12;

  localparam int DIV_W  = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
  localparam int RST_W  = $clog2(RST_CYCLES + 1);
  localparam int WAIT_W = $clog2(BSY_TIMEOUT + 1);

  logic [3:0]        state;
  logic [DIV_W-1:0]  div_cnt;
  logic [RST_W-1:0]  rst_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [8:0]        bit_cnt;
  logic              start_d;
  logic              go;        // condition met, act on the next SCLK edge tick
  logic              bsy_seen;  // BSY observed high while Drdy was up
  logic [255:0]      sr;        // {key, pt} scan-in shift register
  logic [127:0]      ct_sr;     // scan-out accumulator
  logic [127:0]      exp_r;

  logic running, tick, rise_tick, fall_tick;
  logic start_edge, begin_run, chain_go, run_go;
  logic wait_state, bsy_ok, expire, sr_shift, ct_shift;

  assign running   = (state != S_IDLE) && (state != S_DONE);
  assign tick      = running && (div_cnt == DIV_W'(SCLK_DIV - 1));
  assign rise_tick = tick && !SCLK;
  assign fall_tick = tick && SCLK;

  assign start_edge = start && !start_d;
  assign begin_run  = start_edge && ((state == S_IDLE) || (state == S_DONE));
  assign run_go     = begin_run || chain_go;

  assign wait_state = (state == S_WAIT_KEY) || (state == S_WAIT_HI) || (state == S_WAIT_LO);

  always_comb begin
    // NOTE: default first so every path assigns bsy_ok and no latch is inferred.
    bsy_ok = 1'b0;
    case (state)
      S_WAIT_KEY, S_WAIT_LO: bsy_ok = !BSY;
      S_WAIT_HI:             bsy_ok = BSY || bsy_seen;
      default:               bsy_ok = 1'b0;
    endcase
  end

  // Last allowed BSY sample in a wait state still not satisfied.
  assign expire = wait_state && rise_tick && !go && !bsy_ok &&
                  (wait_cnt == WAIT_W'(BSY_TIMEOUT - 1));

  // The first key bit is presented on the fall tick that leaves CORE_RST.
  assign sr_shift = fall_tick && (((state == S_CORE_RST) && go) ||
                                  ((state == S_SHIFT_IN) && (bit_cnt != 9'd255)));
  assign ct_shift = rise_tick && (state == S_SHIFT_OUT) && (bit_cnt != 9'd128);

`ifdef AES_SEQ_CHAIN_EN
  logic [3:0]   chain_cnt;
  logic [127:0] key_r;
  assign chain_go = (state == S_DONE) && start && pass && !start_edge && (chain_cnt == 4'd15);

  always_ff @(posedge CLK) begin
    if (reset || (state != S_DONE) || !start || !pass || start_edge || chain_go)
      chain_cnt <= '0;
    else
      chain_cnt <= chain_cnt + 4'd1;
  end
`else
  assign chain_go = 1'b0;
`endif

  // SCLK divider; forced low on the cycle a wait expires so no runt pulse
  // reaches the ASIC on the way into DONE.
  always_ff @(posedge CLK) begin
    if (reset || !running || expire) begin
      div_cnt <= '0;
      SCLK    <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      SCLK    <= !SCLK;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // NOTE: datapath shift registers carry no reset; each run loads them before
  // any bit is used, and only control state needs a defined reset value.
  always_ff @(posedge CLK) begin
    if (begin_run) begin
      sr    <= {key_in, pt_in};
      exp_r <= expected;
`ifdef AES_SEQ_CHAIN_EN
      key_r <= key_in;
    end else if (chain_go) begin
      sr    <= {key_r, ct_out};
      exp_r <= expected_next;
`endif
    end else if (sr_shift) begin
      sr <= {sr[254:0], 1'b0};
    end
    if (ct_shift) ct_sr <= {ct_sr[126:0], SO};
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= S_IDLE;
      RSTn     <= 1'b0;
      EN       <= 1'b0;
      SU       <= 1'b0;
      SE       <= 1'b0;
      SI       <= 1'b0;
      Krdy     <= 1'b0;
      Drdy     <= 1'b0;
      ct_out   <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
      start_d  <= 1'b0;
      rst_cnt  <= '0;
      wait_cnt <= '0;
      bit_cnt  <= '0;
      go       <= 1'b0;
      bsy_seen <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch reads pre-edge values.
      start_d <= start;
      if (expire) begin
        timeout <= 1'b1;
        fail    <= 1'b1;
        done    <= 1'b1;
        RSTn    <= 1'b0;
        state   <= S_DONE;
      end else begin
        case (state)
          S_IDLE, S_DONE: if (run_go) begin
            state   <= S_CORE_RST;
            RSTn    <= 1'b0;
            rst_cnt <= '0;
            go      <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            fail    <= 1'b0;
            timeout <= 1'b0;
          end
          S_CORE_RST: begin
            if (!go) begin
              if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
                RSTn <= 1'b1;
                EN   <= 1'b1;
                go   <= 1'b1;
              end else begin
                rst_cnt <= rst_cnt + 1'b1;
              end
            end else if (fall_tick) begin
              state   <= S_SHIFT_IN;
              SE      <= 1'b1;
              SI      <= sr[255];
              bit_cnt <= '0;
              go      <= 1'b0;
            end
          end
          S_SHIFT_IN: if (fall_tick) begin
            bit_cnt <= bit_cnt + 9'd1;
            if (bit_cnt == 9'd255) begin
              SE    <= 1'b0;
              SI    <= 1'b0;
              SU    <= 1'b1;
              state <= S_UPDATE;
            end else begin
              SI <= sr[255];
            end
          end
          S_UPDATE: if (fall_tick) begin
            SU    <= 1'b0;
            Krdy  <= 1'b1;
            state <= S_KEY_RDY;
          end
          S_KEY_RDY: if (fall_tick) begin
            Krdy     <= 1'b0;
            wait_cnt <= '0;
            go       <= 1'b0;
            state    <= S_WAIT_KEY;
          end
          S_WAIT_KEY, S_WAIT_LO: begin
            if (go && fall_tick) begin
              go <= 1'b0;
              if (state == S_WAIT_KEY) begin
                Drdy     <= 1'b1;
                bsy_seen <= 1'b0;
                state    <= S_DATA_RDY;
              end else begin
                SU    <= 1'b1;
                state <= S_CAPTURE;
              end
            end else if (rise_tick && !go) begin
              if (bsy_ok) go <= 1'b1;
              else        wait_cnt <= wait_cnt + 1'b1;
            end
          end
          S_DATA_RDY: begin
            // Sampled every CLK so a BSY pulse shorter than the Drdy period
            // still counts as the ASIC having gone busy.
            if (BSY) bsy_seen <= 1'b1;
            if (fall_tick) begin
              Drdy     <= 1'b0;
              wait_cnt <= '0;
              state    <= S_WAIT_HI;
            end
          end
          S_WAIT_HI: if (rise_tick) begin
            if (bsy_ok) begin
              wait_cnt <= '0;
              go       <= 1'b0;
              state    <= S_WAIT_LO;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          S_CAPTURE: if (fall_tick) begin
            SU      <= 1'b0;
            SE      <= 1'b1;
            bit_cnt <= '0;
            state   <= S_SHIFT_OUT;
          end
          S_SHIFT_OUT: begin
            if (rise_tick && (bit_cnt != 9'd128)) begin
              bit_cnt <= bit_cnt + 9'd1;
            end else if (fall_tick && (bit_cnt == 9'd128)) begin
              SE     <= 1'b0;
              ct_out <= ct_sr;
              state  <= S_COMPARE;
            end
          end
          S_COMPARE: begin
            pass  <= (ct_out == exp_r);
            fail  <= (ct_out != exp_r);
            done  <= 1'b1;
            state <= S_DONE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_scan_sequencer.sv
// tb_aes_scan_sequencer
// Bench for aes_scan_sequencer with a behavioural model of the AES test ASIC
// (256-bit scan chain, fixed FIPS-197 ciphertext, BSY held for 40 SCLK after
// Drdy). Expected scan loads and run results are queued by the stimulus and
// consumed by the ASIC model and a done monitor.

module tb_aes_scan_sequencer;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         CLK = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] pt_in = '0;
  logic [127:0] expected = '0;
  logic         SO, BSY;
  logic         RSTn, EN, SU, SE, SI, SCLK, Krdy, Drdy;
  logic [127:0] ct_out;
  logic         done, pass, fail, timeout;

  always #5 CLK = ~CLK;

  aes_scan_sequencer dut (
    .CLK(CLK), .reset(reset), .start(start),
    .key_in(key_in), .pt_in(pt_in), .expected(expected),
`ifdef AES_SEQ_CHAIN_EN
    .expected_next(expected),
`endif
    .SO(SO), .BSY(BSY),
    .RSTn(RSTn), .EN(EN), .SU(SU), .SE(SE), .SI(SI), .SCLK(SCLK),
    .Krdy(Krdy), .Drdy(Drdy), .ct_out(ct_out),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [127:0] ct;
    logic         pass;
    logic         fail;
    logic         timeout;
    logic         rstn;
  } result_t;

  result_t      res_q[$];
  logic [255:0] load_q[$];

  // ---------------- ASIC model ----------------
  logic [255:0] chain = '0;
  logic         loaded = 1'b0;
  logic         bsy_m = 1'b0;
  int           bsy_cnt = 0;
  int           shift_in_cnt = 0;
  int           model_mode = 0;   // 0: normal, 1: BSY never rises
  logic [255:0] exp_load;

  assign SO  = chain[255];
  assign BSY = bsy_m;

  always @(posedge SCLK or negedge RSTn) begin
    if (!RSTn) begin
      loaded       <= 1'b0;
      bsy_m        <= 1'b0;
      bsy_cnt      <= 0;
      shift_in_cnt <= 0;
    end else begin
      if (SE) begin
        chain <= {chain[254:0], SI};
        if (!loaded) shift_in_cnt <= shift_in_cnt + 1;
      end else if (SU && !loaded) begin
        loaded <= 1'b1;
        if (load_q.size() == 0) begin
          check_bit("unexpected_scan_load", 1'b1, 1'b0);
        end else begin
          exp_load = load_q.pop_front();
          check_vec("scan_key", chain[255:128], exp_load[255:128]);
          check_vec("scan_pt", chain[127:0], exp_load[127:0]);
        end
      end else if (SU && loaded) begin
        chain[255:128] <= CT;
      end
      if (Drdy && model_mode == 0) begin
        bsy_m   <= 1'b1;
        bsy_cnt <= 40;
      end else if (bsy_cnt > 1) begin
        bsy_cnt <= bsy_cnt - 1;
      end else if (bsy_cnt == 1) begin
        bsy_cnt <= 0;
        bsy_m   <= 1'b0;
      end
    end
  end

  // ---------------- result monitor ----------------
  logic    done_q = 1'b0;
  result_t mon_r;

  always @(negedge CLK) begin
    if (done && !done_q) begin
      if (res_q.size() == 0) begin
        check_bit("unexpected_done", 1'b1, 1'b0);
      end else begin
        mon_r = res_q.pop_front();
        check_vec("ct_out", ct_out, mon_r.ct);
        check_bit("pass", pass, mon_r.pass);
        check_bit("fail", fail, mon_r.fail);
        check_bit("timeout", timeout, mon_r.timeout);
        check_bit("rstn_at_done", RSTn, mon_r.rstn);
      end
    end
    done_q = done;
  end

  // ---------------- stimulus ----------------
  task automatic do_start();
    @(negedge CLK) start = 1'b1;
    repeat (4) @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      @(negedge CLK);
      n++;
    end
    if (!done) check_bit("run_completes", 1'b0, 1'b1);
    repeat (5) @(negedge CLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic sclk_seen;
    int   n;

    // Reset held 10 cycles, then idle for 200 cycles with start low.
    reset = 1'b1;
    repeat (10) @(negedge CLK);
    reset = 1'b0;
    sclk_seen = 1'b0;
    repeat (200) begin
      @(negedge CLK);
      if (SCLK !== 1'b0) sclk_seen = 1'b1;
    end
    check_vec("idle_outputs",
              128'({RSTn, EN, SU, SE, SI, SCLK, Krdy, Drdy, done, pass, fail, timeout}), '0);
    check_vec("idle_ct_out", ct_out, '0);
    check_bit("idle_sclk_static", sclk_seen, 1'b0);

    // FIPS-197 vector, expected match.
    key_in = KEY; pt_in = PT; expected = CT;
    load_q.push_back({KEY, PT});
    res_q.push_back('{ct: CT, pass: 1'b1, fail: 1'b0, timeout: 1'b0, rstn: 1'b1});
    do_start();
    wait_done(20000);

    // Reference with bit 0 flipped; inputs scrambled after start to show latching.
    expected = CT ^ 128'h1;
    load_q.push_back({KEY, PT});
    res_q.push_back('{ct: CT, pass: 1'b0, fail: 1'b1, timeout: 1'b0, rstn: 1'b1});
    do_start();
    key_in = ~KEY; pt_in = '0; expected = '0;
    wait_done(20000);

    // BSY never rises: WAIT_HI times out, ct_out keeps the previous run's value.
    model_mode = 1;
    key_in = KEY; pt_in = PT; expected = CT;
    load_q.push_back({KEY, PT});
    res_q.push_back('{ct: CT, pass: 1'b0, fail: 1'b1, timeout: 1'b1, rstn: 1'b0});
    do_start();
    wait_done(45000);
    model_mode = 0;

    // Reset during scan-in bit 100.
    do_start();
    n = 0;
    while (shift_in_cnt < 100 && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    check_bit("reached_bit_100", shift_in_cnt >= 100, 1'b1);
    @(negedge CLK) reset = 1'b1;
    @(posedge CLK) #1;
    check_vec("abort_outputs",
              128'({RSTn, EN, SU, SE, SI, SCLK, Krdy, Drdy, done, pass, fail, timeout}), '0);
    check_vec("abort_ct_out", ct_out, '0);
    @(negedge CLK) reset = 1'b0;
    repeat (20) @(negedge CLK);

    // Second start during WAIT_LO must be ignored; exactly one run completes.
    load_q.push_back({KEY, PT});
    res_q.push_back('{ct: CT, pass: 1'b1, fail: 1'b0, timeout: 1'b0, rstn: 1'b1});
    do_start();
    n = 0;
    while (BSY !== 1'b1 && n < 6000) begin
      @(negedge CLK);
      n++;
    end
    check_bit("bsy_raised", BSY, 1'b1);
    repeat (20) @(negedge CLK);
    do_start();
    wait_done(20000);
    repeat (400) @(negedge CLK);
    check_bit("done_sticky", done, 1'b1);

    check_vec("results_drained", 128'(res_q.size()), '0);
    check_vec("loads_drained", 128'(load_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
